// File: rtl/switch_allocator.sv
// switch_allocator: output-side stage of the router.
// Each output is arbitrated round-robin among its requesting inputs.
// The winner is held for the whole packet, from head flit to tail flit.
// Downstream credits are tracked per output VC.
// Winning flits are registered onto the router outputs.
module switch_allocator #(
  parameter int PORTS     = 5,
  parameter int VC_NUM    = 4,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4,
  parameter int PB        = 3,
  parameter int VB        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS*FLIT_SIZE-1:0]  in_flit,
  input  logic [PORTS-1:0]            in_valid,
  input  logic [PORTS*PB-1:0]         in_dest,
  input  logic [PORTS*VB-1:0]         in_vc,
  output logic [PORTS-1:0]            in_grant,
  input  logic [PORTS*VC_NUM-1:0]     credit_in,
  output logic [PORTS*FLIT_SIZE-1:0]  out_flit,
  output logic [PORTS-1:0]            out_valid,
  output logic [PORTS*VB-1:0]         out_vc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  logic                 lock_q   [PORTS];
  logic [PB-1:0]        owner_q  [PORTS];
  logic [PB-1:0]        rr_q     [PORTS];
  logic [CW-1:0]        credit_q [PORTS][VC_NUM];

  logic [FLIT_SIZE-1:0] flit_a   [PORTS];
  logic [1:0]           type_a   [PORTS];
  logic [PB-1:0]        dest_a   [PORTS];
  logic [VB-1:0]        vc_a     [PORTS];

  logic [PORTS-1:0]     cand     [PORTS];
  logic                 win_any  [PORTS];
  logic [PB-1:0]        win_idx  [PORTS];
  logic [VC_NUM-1:0]    send_vc  [PORTS];

  // Split the flat input buses into per-input fields
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      flit_a[i] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
      type_a[i] = in_flit[i*FLIT_SIZE + FLIT_SIZE - 1 -: 2];
      dest_a[i] = in_dest[i*PB +: PB];
      vc_a[i]   = in_vc[i*VB +: VB];
    end
  end

  // Eligibility: a free output takes packet starts; a locked one takes only its owner's continuation
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < PORTS; i++) begin
        cand[o][i] = in_valid[i]
                  && (dest_a[i] == PB'(o))
                  && (int'(vc_a[i]) < VC_NUM)
                  && (credit_q[o][vc_a[i]] != '0)
                  && (lock_q[o] ? ((owner_q[o] == PB'(i)) &&
                                   ((type_a[i] == T_BODY) || (type_a[i] == T_TAIL)))
                                : ((type_a[i] == T_SINGLE) || (type_a[i] == T_HEAD)));
      end
    end
  end

  // Round-robin pick per output, scanning upward from the pointer
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < PORTS; o++) begin
      win_any[o] = 1'b0;
      win_idx[o] = '0;
      for (int k = 0; k < PORTS; k++) begin
        idx = (int'(rr_q[o]) + k) % PORTS;
        if (!win_any[o] && cand[o][idx]) begin
          win_any[o] = 1'b1;
          win_idx[o] = PB'(idx);
        end
      end
    end
  end

  // Grants back to the inputs and the VC consumed on each output this cycle
  always_comb begin
    in_grant = '0;
    for (int o = 0; o < PORTS; o++) begin
      send_vc[o] = '0;
      if (win_any[o]) begin
        in_grant[win_idx[o]]       = 1'b1;
        send_vc[o][vc_a[win_idx[o]]] = 1'b1;
      end
    end
  end

  // Output registers plus the per-output lock, owner and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_flit  <= '0;
      out_valid <= '0;
      out_vc    <= '0;
      for (int o = 0; o < PORTS; o++) begin
        lock_q[o]  <= 1'b0;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        out_valid[o] <= win_any[o];
        if (win_any[o]) begin
          out_flit[o*FLIT_SIZE +: FLIT_SIZE] <= flit_a[win_idx[o]];
          out_vc[o*VB +: VB]                 <= vc_a[win_idx[o]];
          case (type_a[win_idx[o]])
            T_HEAD: begin
              lock_q[o]  <= 1'b1;
              owner_q[o] <= win_idx[o];
              rr_q[o]    <= PB'((int'(win_idx[o]) + 1) % PORTS);
            end
            T_SINGLE: rr_q[o] <= PB'((int'(win_idx[o]) + 1) % PORTS);
            T_TAIL:   lock_q[o] <= 1'b0;
            default:  ;
          endcase
        end
      end
    end
  end

  // Credit counters: a send and a return on the same VC cancel; returns saturate at full depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < PORTS; o++)
        for (int v = 0; v < VC_NUM; v++)
          credit_q[o][v] <= CW'(BUF_DEPTH);
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (send_vc[o][v] && !credit_in[o*VC_NUM + v])
            credit_q[o][v] <= credit_q[o][v] - CW'(1);
          else if (!send_vc[o][v] && credit_in[o*VC_NUM + v] &&
                   (credit_q[o][v] != CW'(BUF_DEPTH)))
            credit_q[o][v] <= credit_q[o][v] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed, scoreboard-checked bench for switch_allocator.
module tb_switch_allocator;

  localparam int PORTS     = 5;
  localparam int VC_NUM    = 4;
  localparam int FLIT_SIZE = 32;
  localparam int BUF_DEPTH = 4;
  localparam int PB        = 3;
  localparam int VB        = 2;

  localparam logic [1:0] T_S = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_B = 2'b10;
  localparam logic [1:0] T_T = 2'b11;

  typedef struct packed {
    logic [PORTS-1:0]           valid;
    logic [PORTS*FLIT_SIZE-1:0] flit;
    logic [PORTS*VB-1:0]        vc;
  } exp_t;

  logic                       clk;
  logic                       reset;
  logic [PORTS*FLIT_SIZE-1:0] in_flit;
  logic [PORTS-1:0]           in_valid;
  logic [PORTS*PB-1:0]        in_dest;
  logic [PORTS*VB-1:0]        in_vc;
  logic [PORTS-1:0]           in_grant;
  logic [PORTS*VC_NUM-1:0]    credit_in;
  logic [PORTS*FLIT_SIZE-1:0] out_flit;
  logic [PORTS-1:0]           out_valid;
  logic [PORTS*VB-1:0]        out_vc;

  exp_t                       sb_q[$];
  logic [PORTS*FLIT_SIZE-1:0] exp_flit;
  logic [PORTS*VB-1:0]        exp_vc;
  int                         vectors;
  int                         miscompares;

  switch_allocator #(
    .PORTS(PORTS), .VC_NUM(VC_NUM), .FLIT_SIZE(FLIT_SIZE),
    .BUF_DEPTH(BUF_DEPTH), .PB(PB), .VB(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_flit(in_flit), .in_valid(in_valid), .in_dest(in_dest), .in_vc(in_vc),
    .in_grant(in_grant), .credit_in(credit_in),
    .out_flit(out_flit), .out_valid(out_valid), .out_vc(out_vc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench ever gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    in_flit  = '0;
    in_valid = '0;
    in_dest  = '0;
    in_vc    = '0;
  endtask

  task automatic apply_stimulus(input int i, input logic [1:0] ftype, input logic [29:0] payload,
                                input int dest, input int vc);
    in_flit[i*FLIT_SIZE +: FLIT_SIZE] = {ftype, payload};
    in_valid[i]                       = 1'b1;
    in_dest[i*PB +: PB]               = PB'(dest);
    in_vc[i*VB +: VB]                 = VB'(vc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " valid"}, 32'(out_valid), 32'h0);
    for (int o = 0; o < PORTS; o++) begin
      check_output($sformatf("%s out%0d flit", tag, o), out_flit[o*FLIT_SIZE +: FLIT_SIZE], 32'h0);
      check_output($sformatf("%s out%0d vc", tag, o), 32'(out_vc[o*VB +: VB]), 32'h0);
    end
  endtask

  // One clock: check grants mid-cycle, push the expected outputs, then compare them after the edge
  task automatic run_cycle(input logic [PORTS-1:0] exp_grant, input string tag);
    exp_t e;
    int   o;
    #3;
    check_output({tag, " grant"}, 32'(in_grant), 32'(exp_grant));
    e.valid = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (exp_grant[i]) begin
        o = int'(in_dest[i*PB +: PB]);
        exp_flit[o*FLIT_SIZE +: FLIT_SIZE] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
        exp_vc[o*VB +: VB]                 = in_vc[i*VB +: VB];
        e.valid[o]                         = 1'b1;
      end
    end
    e.flit = exp_flit;
    e.vc   = exp_vc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    credit_in = '0;
    e = sb_q.pop_front();
    check_output({tag, " out_valid"}, 32'(out_valid), 32'(e.valid));
    for (int p = 0; p < PORTS; p++) begin
      check_output($sformatf("%s out%0d flit", tag, p),
                   out_flit[p*FLIT_SIZE +: FLIT_SIZE], e.flit[p*FLIT_SIZE +: FLIT_SIZE]);
      check_output($sformatf("%s out%0d vc", tag, p),
                   32'(out_vc[p*VB +: VB]), 32'(e.vc[p*VB +: VB]));
    end
  endtask

  initial begin
    int order[3];
    vectors     = 0;
    miscompares = 0;
    exp_flit    = '0;
    exp_vc      = '0;
    credit_in   = '0;
    clear_inputs();
    reset = 1'b0;

    #12;
    check_idle_outputs("reset");
    check_output("reset grant", 32'(in_grant), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single flit from input 2 to output 1 on VC 3
    clear_inputs();
    apply_stimulus(2, T_S, 30'hA5, 1, 3);
    run_cycle(5'b00100, "single");

    // Three streams of single flits into output 0 rotate 0, 3, 4
    order[0] = 0; order[1] = 3; order[2] = 4;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      apply_stimulus(0, T_S, 30'h100 + 30'(c), 0, 0);
      apply_stimulus(3, T_S, 30'h200 + 30'(c), 0, 1);
      apply_stimulus(4, T_S, 30'h300 + 30'(c), 0, 2);
      run_cycle(PORTS'(1) << order[c % 3], $sformatf("rr%0d", c));
    end

    // Wormhole lock on output 2; a stray body to free output 4 must stall
    clear_inputs();
    apply_stimulus(1, T_H, 30'h11, 2, 0);
    apply_stimulus(4, T_B, 30'h44, 4, 0);
    run_cycle(5'b00010, "worm head");
    clear_inputs();
    apply_stimulus(1, T_B, 30'h12, 2, 0);
    apply_stimulus(0, T_H, 30'h01, 2, 1);
    apply_stimulus(4, T_B, 30'h44, 4, 0);
    run_cycle(5'b00010, "worm body");
    clear_inputs();
    apply_stimulus(1, T_T, 30'h13, 2, 0);
    apply_stimulus(0, T_H, 30'h01, 2, 1);
    run_cycle(5'b00010, "worm tail");
    clear_inputs();
    apply_stimulus(0, T_H, 30'h01, 2, 1);
    run_cycle(5'b00001, "worm next head");
    clear_inputs();
    apply_stimulus(0, T_T, 30'h02, 2, 1);
    run_cycle(5'b00001, "worm next tail");

    // Credit exhaustion on output 3 VC 0, then one returned credit
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      apply_stimulus(0, T_S, 30'h30 + 30'(c), 3, 0);
      if (c == 5) credit_in[3*VC_NUM + 0] = 1'b1;
      run_cycle((c < 4 || c == 6) ? 5'b00001 : 5'b00000, $sformatf("credit%0d", c));
    end

    // Send and return on output 1 VC 2 in the same cycle: five sends, one return, four credits
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      apply_stimulus(0, T_S, 30'h50 + 30'(c), 1, 2);
      if (c == 2) credit_in[1*VC_NUM + 2] = 1'b1;
      run_cycle((c < 5) ? 5'b00001 : 5'b00000, $sformatf("sendret%0d", c));
    end

    // A return on a full VC (output 1 VC 1) must not raise it past four
    clear_inputs();
    credit_in[1*VC_NUM + 1] = 1'b1;
    run_cycle(5'b00000, "sat return");
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      apply_stimulus(3, T_S, 30'h60 + 30'(c), 1, 1);
      run_cycle((c < 4) ? 5'b01000 : 5'b00000, $sformatf("sat%0d", c));
    end

    // Reset between head and tail on output 4
    clear_inputs();
    apply_stimulus(2, T_H, 30'h21, 4, 0);
    run_cycle(5'b00100, "prereset head");
    clear_inputs();
    apply_stimulus(2, T_B, 30'h22, 4, 0);
    reset = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check_output("async reset grant", 32'(in_grant), 32'h0);
    exp_flit = '0;
    exp_vc   = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh head to output 4 and full credits on output 3 VC 0 right after release
    clear_inputs();
    apply_stimulus(3, T_H, 30'h33, 4, 0);
    apply_stimulus(0, T_S, 30'h3C, 3, 0);
    run_cycle(5'b01001, "post reset");
    clear_inputs();
    apply_stimulus(3, T_T, 30'h34, 4, 0);
    run_cycle(5'b01000, "post reset tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Output-side stage of the router. It takes the head-of-line flit from every input port's VC buffer, arbitrates the output ports round-robin, and tracks downstream credits per output VC. It switches the winning flits through a registered crossbar to the router outputs. Packets are wormhole-locked on an output from head flit to tail flit.

## Interface
Parameters:
- PORTS, 5, number of input and output ports (ports indexed 0..PORTS-1)
- VC_NUM, 4, virtual channels per port
- FLIT_SIZE, 32, flit width; bits [FLIT_SIZE-1:FLIT_SIZE-2] are the flit type
- BUF_DEPTH, 4, downstream VC buffer depth (initial credits per output VC)
- PB, 3, width of a port index (≥ clog2(PORTS))
- VB, 2, width of a VC index (≥ clog2(VC_NUM))

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- in_flit  input  PORTS*FLIT_SIZE  head-of-line flit per input; port i at [i*FLIT_SIZE +: FLIT_SIZE]
- in_valid  input  PORTS  flit present on input i
- in_dest  input  PORTS*PB  output port requested by input i (already routed)
- in_vc  input  PORTS*VB  VC of the flit on input i, kept unchanged downstream
- in_grant  output  PORTS  combinational; flit on input i is taken this cycle and must be popped
- credit_in  input  PORTS*VC_NUM  one-cycle credit-return pulse, bit o*VC_NUM+v
- out_flit  output  PORTS*FLIT_SIZE  registered flit per output
- out_valid  output  PORTS  registered valid per output
- out_vc  output  PORTS*VB  registered VC per output

## Operation
- Flit type encoding:
  - 00 single (head and tail)
  - 01 head
  - 10 body
  - 11 tail
- Per-output state:
  - lock flag
  - owner (PB bits)
  - rr_ptr (PB bits)
  - credit counter per VC, width clog2(BUF_DEPTH+1)
- Output o, unlocked:
  - Candidates are inputs i with in_valid[i], in_dest[i]==o, type head or single, and credit[o][in_vc[i]] > 0.
  - The first candidate scanning from rr_ptr upward (mod PORTS) wins.
  - Body or tail flits toward an unlocked output are never granted (protocol error). They stall.
- Output o, locked:
  - Only the owner is eligible, with in_valid, in_dest==o, type body or tail, and credit>0.
  - Other inputs stall.
- Any input is granted on at most one output per cycle, which is implied by having a single in_dest.
- On a grant of input i to output o (at the clock edge):
  - out_flit/out_vc/out_valid[o] load the flit.
  - credit[o][vc] decrements.
  - A head grant sets lock=1 and owner=i, and sets rr_ptr=(i+1) mod PORTS.
  - A single-flit grant sets rr_ptr=(i+1) mod PORTS and leaves lock unchanged (0).
  - A tail grant clears lock.
- No grant on output o: out_valid[o]=0 next cycle; out_flit holds its old value.
- Credit return pulse: credit[o][v] increments, saturating at BUF_DEPTH.
- Send and return on the same VC in the same cycle: the counter is unchanged.

## Timing
- Reset (reset=0, asynchronous) sets:
  - out_valid=0, out_flit=0, out_vc=0
  - all locks=0, owners=0, rr_ptr=0
  - all credits=BUF_DEPTH
  - in_grant is then determined by the reset state only.
- in_grant is combinational from registered state and same-cycle inputs; it has no dependence on credit_in of the same cycle.
- Latency: a flit granted in cycle N appears on out_flit with out_valid=1 in cycle N+1.
- Throughput: one flit per output per cycle. Back-to-back packets on one output are allowed: a tail in cycle N and a new head in cycle N+1.
- A credit returned in cycle N is usable for a grant in cycle N+1.
- A VC with credit 0 blocks. The locked packet stays locked during the stall, with no timeout.
- Reset asserted mid-packet drops all locks and restores full credits. Any flit in flight is lost, and the surrounding system is reset together.

## Test plan
- Single-flit path: after reset, input 2 presents a single flit 0x0000_00A5 with dest=1 and vc=3. Required: in_grant[2]=1 that cycle. Next cycle out_valid[1]=1, out_flit[1]=0x0000_00A5, out_vc[1]=3, and credit[1][3]=3.
- Round-robin fairness: inputs 0, 3 and 4 each send a continuous stream of single flits to output 0. Required: grants in order 0, 3, 4, 0, 3, 4, … with one flit per cycle on out 0.
- Wormhole lock: input 1 sends head/body/tail to out 2 while input 0 offers a head to out 2 from cycle 1. Required:
  - Input 0 is not granted until the cycle after input 1's tail is granted.
  - out 2 carries H, B, T from input 1 contiguously.
- Credit exhaustion: BUF_DEPTH=4, no credit returns, five single flits from input 0 to out 3 vc 0. Required: four grants, then in_grant[0]=0. A credit_in pulse on bit 3*VC_NUM+0 in cycle N gives a grant in cycle N+1.
- Simultaneous send and return: with credit[1][2]=2, grant on out 1 vc 2 and a credit_in pulse on the same VC in the same cycle. Required: credit stays 2. A return while credit=4 leaves it at 4.
- Async reset mid-packet: assert reset between head and tail. Required:
  - Outputs go to 0 immediately, without a clock edge.
  - After release, a new head from any input to that output is grantable on the first cycle.
